// File: rtl/image_pkg.sv
// Shared types and defaults for the image buffer consumers: window tags,
// fetch FSM encoding and the buffer address width helper.
package image_pkg;

  localparam int DEF_IMG_WIDTH  = 45;
  localparam int DEF_IMG_HEIGHT = 45;
  localparam int DEF_WIN_SIZE   = 24;
  localparam int W_COORD        = 16;

  function automatic int addr_width(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

  // Coordinates are carried at a fixed width; consumers slice to their port width.
  typedef struct packed {
    logic               sow;
    logic               eow;
    logic [W_COORD-1:0] win_x;
    logic [W_COORD-1:0] win_y;
  } win_tag_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with valid/ready on both sides; storage is reset so
// the read port never shows X.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int W_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int W_CNT = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [W_PTR-1:0]            wr_ptr, rd_ptr;
  logic [W_CNT-1:0]            count;
  logic                        push, pop;

  assign in_ready  = (count != W_CNT'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= (wr_ptr == W_PTR'(DEPTH - 1)) ? '0 : wr_ptr + W_PTR'(1);
      end
      if (pop)
        rd_ptr <= (rd_ptr == W_PTR'(DEPTH - 1)) ? '0 : rd_ptr + W_PTR'(1);
      case ({push, pop})
        2'b10:   count <= count + W_CNT'(1);
        2'b01:   count <= count - W_CNT'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/window_fetch.sv
// Scans every WIN_SIZE x WIN_SIZE window of the resident frame, issues one
// buffer read per window pixel under credit control, and re-streams the pixels tagged.
module window_fetch
  import image_pkg::*;
#(
  parameter int  W_DATA     = 8,
  parameter int  IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int  IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int  WIN_SIZE   = DEF_WIN_SIZE,
  parameter int  STEP       = 1,
  parameter int  RD_LAT     = 1,
  localparam int W_ADDR     = addr_width(IMG_WIDTH, IMG_HEIGHT),
  localparam int W_X        = $clog2(IMG_WIDTH),
  localparam int W_Y        = $clog2(IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [W_ADDR-1:0] addr_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [W_DATA-1:0] pix_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [W_DATA-1:0] dout_data,
  output logic              dout_sow,
  output logic              dout_eow,
  output logic [W_X-1:0]    dout_win_x,
  output logic [W_Y-1:0]    dout_win_y,
  output logic              done
);

  localparam int DEPTH  = RD_LAT + 1;
  localparam int W_CRED = $clog2(DEPTH + 1);
  localparam int W_P    = $clog2(WIN_SIZE + 1);
  localparam int W_FIFO = W_DATA + $bits(win_tag_t);

  localparam logic [W_P-1:0]    P_LAST      = W_P'(WIN_SIZE - 1);
  localparam logic [W_X-1:0]    X_LAST      = W_X'(((IMG_WIDTH - WIN_SIZE) / STEP) * STEP);
  localparam logic [W_Y-1:0]    Y_LAST      = W_Y'(((IMG_HEIGHT - WIN_SIZE) / STEP) * STEP);
  localparam logic [W_ADDR-1:0] ROW_INC     = W_ADDR'(IMG_WIDTH);
  localparam logic [W_ADDR-1:0] WIN_ROW_INC = W_ADDR'(STEP * IMG_WIDTH);

  fetch_state_t      state, state_nxt;
  logic [W_X-1:0]    win_x;
  logic [W_Y-1:0]    win_y;
  logic [W_P-1:0]    px, py;
  logic [W_ADDR-1:0] row_base, win_base;
  logic [W_CRED-1:0] cred;
  logic [RD_LAT:1]   vld_pipe;
  win_tag_t          tag_pipe [1:RD_LAT];
  win_tag_t          cur_tag, out_tag;
  logic              take, ret, last_addr, start_go;
  logic              fifo_in_valid, fifo_in_ready;
  logic [W_FIFO-1:0] fifo_in_data, fifo_out_data;
  logic              unused_tag_hi;

  assign start_ready = rst & (state == IDLE);
  assign pix_ready   = rst;
  assign start_go    = start_valid & start_ready;

  assign take      = addr_valid & addr_ready;
  assign ret       = dout_valid & dout_ready;
  assign last_addr = (px == P_LAST) && (py == P_LAST) && (win_x == X_LAST) && (win_y == Y_LAST);

  // A credit returning this cycle may be spent immediately; this keeps one
  // pixel per cycle with only RD_LAT+1 slots, and once raised addr_valid
  // cannot drop because an unspent return always lands in cred.
  assign addr_valid = (state == ISSUE) && ((cred != '0) || ret);
  assign addr_data  = row_base + W_ADDR'(win_x) + W_ADDR'(px);

  always_comb begin
    cur_tag       = '0;
    cur_tag.sow   = (px == '0) && (py == '0);
    cur_tag.eow   = (px == P_LAST) && (py == P_LAST);
    cur_tag.win_x = W_COORD'(win_x);
    cur_tag.win_y = W_COORD'(win_y);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      IDLE:    if (start_go) state_nxt = ISSUE;
      ISSUE:   if (take && last_addr) state_nxt = DRAIN;
      DRAIN:   if (!dout_valid && (vld_pipe == '0)) begin
                 state_nxt = IDLE;
                 done      = 1'b1;
               end
      default: state_nxt = IDLE;
    endcase
  end

  // Address walk: row_base tracks (win_y+py)*IMG_WIDTH by accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px <= '0; py <= '0; win_x <= '0; win_y <= '0;
      row_base <= '0; win_base <= '0;
    end else if (start_go || (take && last_addr)) begin
      px <= '0; py <= '0; win_x <= '0; win_y <= '0;
      row_base <= '0; win_base <= '0;
    end else if (take) begin
      if (px != P_LAST) begin
        px <= px + W_P'(1);
      end else begin
        px <= '0;
        if (py != P_LAST) begin
          py       <= py + W_P'(1);
          row_base <= row_base + ROW_INC;
        end else begin
          py <= '0;
          if (win_x != X_LAST) begin
            win_x    <= win_x + W_X'(STEP);
            row_base <= win_base;
          end else begin
            win_x    <= '0;
            win_y    <= win_y + W_Y'(STEP);
            win_base <= win_base + WIN_ROW_INC;
            row_base <= win_base + WIN_ROW_INC;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cred <= W_CRED'(DEPTH);
    else if (take && !ret)  cred <= cred - W_CRED'(1);
    else if (ret && !take)  cred <= cred + W_CRED'(1);
  end

  // Tags ride alongside the read so they meet their pixel at the FIFO input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      for (int k = 1; k <= RD_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      vld_pipe[1] <= take;
      tag_pipe[1] <= cur_tag;
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign fifo_in_valid = pix_valid & vld_pipe[RD_LAT];
  assign fifo_in_data  = {tag_pipe[RD_LAT], pix_data};

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(W_FIFO)) u_ret_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fifo_in_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (fifo_in_data),
    .out_valid (dout_valid),
    .out_ready (dout_ready),
    .out_data  (fifo_out_data)
  );

  assign {out_tag, dout_data} = fifo_out_data;
  assign dout_sow      = dout_valid & out_tag.sow;
  assign dout_eow      = dout_valid & out_tag.eow;
  assign dout_win_x    = out_tag.win_x[W_X-1:0];
  assign dout_win_y    = out_tag.win_y[W_Y-1:0];
  assign unused_tag_hi = ^{out_tag.win_x[W_COORD-1:W_X], out_tag.win_y[W_COORD-1:W_Y]};

  a_pix_expected: assert property (@(posedge clk) disable iff (!rst) pix_valid |-> vld_pipe[RD_LAT]);
  a_fifo_room:    assert property (@(posedge clk) disable iff (!rst) fifo_in_valid |-> fifo_in_ready);

endmodule

// File: tb/tb_window_fetch.sv
// Directed bench for window_fetch on a 7x6 frame, 3x3 windows, stride 2,
// two-cycle read latency; the buffer returns pix = addr[7:0].
module tb_window_fetch;

  localparam int IW    = 7;
  localparam int IH    = 6;
  localparam int WS    = 3;
  localparam int ST    = 2;
  localparam int RL    = 2;
  localparam int NWIN  = ((IW - WS) / ST + 1) * ((IH - WS) / ST + 1);
  localparam int TOTAL = NWIN * WS * WS;
  localparam int LIMIT = 2000;

  logic       clk = 1'b0, rst = 1'b0;
  logic       start_valid = 1'b0, addr_ready = 1'b0, dout_ready = 1'b0;
  logic       start_ready, addr_valid, pix_valid, pix_ready;
  logic       dout_valid, dout_sow, dout_eow, done;
  logic [5:0] addr_data;
  logic [7:0] pix_data, dout_data;
  logic [2:0] dout_win_x, dout_win_y;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_pk [TOTAL];

  window_fetch #(
    .W_DATA(8), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .WIN_SIZE(WS), .STEP(ST), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_data(addr_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_sow(dout_sow), .dout_eow(dout_eow),
    .dout_win_x(dout_win_x), .dout_win_y(dout_win_y),
    .done(done)
  );

  always #5 clk = ~clk;

  // Buffer model: fixed two-cycle read latency.
  logic       bv0, bv1;
  logic [7:0] bd0, bd1;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bv0 <= 1'b0; bv1 <= 1'b0; bd0 <= '0; bd1 <= '0;
    end else begin
      bv0 <= addr_valid & addr_ready;
      bd0 <= 8'(addr_data);
      bv1 <= bv0;
      bd1 <= bd0;
    end
  end
  assign pix_valid = bv1;
  assign pix_data  = bd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input bit rnd, input int stall_at, input int rst_at, input bit clean);
    int idx = 0, first = 0, last = 0, nsow = 0, neow = 0, outst = 0, maxo = 0;
    bit fin = 1'b0, ahold = 1'b0, dhold = 1'b0;
    logic [15:0] pk, dsav = '0, first_pk = '0, last_pk = '0;
    logic [5:0]  asav = '0;
    @(negedge clk);
    start_valid = 1'b1;
    #1 check("start_ready", start_ready, 1);
    for (int cyc = 1; cyc <= LIMIT && !fin; cyc++) begin
      @(negedge clk);
      start_valid = rnd && (cyc == 5);
      dout_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      addr_ready  = !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + 10);
      #1;
      pk = {dout_data, dout_sow, dout_eow, dout_win_x, dout_win_y};
      if (start_valid) check("start_ready_busy", start_ready, 0);
      if (ahold) check("addr_hold", {addr_valid, addr_data}, {1'b1, asav});
      if (dhold) check("dout_hold", {dout_valid, pk}, {1'b1, dsav});
      if (cyc == stall_at) check("stall_addr", addr_data, 9);
      ahold = addr_valid & !addr_ready;
      asav  = addr_data;
      dhold = dout_valid & !dout_ready;
      dsav  = pk;
      if (addr_valid && addr_ready) outst++;
      if (dout_valid && dout_ready) begin
        outst--;
        if (idx < TOTAL) check("pix", pk, exp_pk[idx]);
        else             check("pix_count_over", idx + 1, TOTAL);
        if (idx == 0) begin first = cyc; first_pk = pk; end
        last = cyc; last_pk = pk;
        nsow += int'(dout_sow);
        neow += int'(dout_eow);
        idx++;
      end
      if (outst > maxo) maxo = outst;
      if (done) begin
        check("done_at_end", idx, TOTAL);
        fin = 1'b1;
      end
      if (rst_at > 0 && idx == rst_at) begin
        #2 rst = 1'b0;
        #1 check("rst_async", {addr_valid, dout_valid, dout_sow, dout_eow, done, start_ready, addr_data}, 0);
        @(posedge clk);
        #1 check("rst_edge", {addr_valid, dout_valid, dout_sow, dout_eow, done, start_ready, addr_data}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 check("restart_ready", start_ready, 1);
        return;
      end
    end
    check("scan_finished", fin, 1);
    check("pix_count", idx, TOTAL);
    check("sow_count", nsow, NWIN);
    check("eow_count", neow, NWIN);
    check("first_pix", first_pk, 16'h0080);
    check("last_pix", last_pk, 16'h2262);
    check("credit_bound", 32'(maxo > RL + 1), 0);
    if (clean) begin
      check("first_latency", first, RL + 2);
      check("no_bubble", last - first + 1, TOTAL);
      check("max_outstanding", maxo, RL + 1);
    end
    repeat (2) begin
      @(negedge clk);
      #1 check("done_once", {done, dout_valid, addr_valid}, 0);
    end
  endtask

  initial begin
    begin
      int n = 0;
      for (int wy = 0; wy <= IH - WS; wy += ST)
        for (int wx = 0; wx <= IW - WS; wx += ST)
          for (int py = 0; py < WS; py++)
            for (int px = 0; px < WS; px++) begin
              exp_pk[n] = {8'((wy + py) * IW + wx + px), 1'(py == 0 && px == 0),
                           1'(py == WS - 1 && px == WS - 1), 3'(wx), 3'(wy)};
              n++;
            end
    end

    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {addr_valid, dout_valid, dout_sow, dout_eow, done, start_ready, pix_ready}, 0);
    check("reset_addr", addr_data, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("idle_ready", {start_ready, pix_ready, addr_valid}, 3'b110);

    run_scan(1'b0, 0, 0, 1'b1);
    run_scan(1'b1, 0, 0, 1'b0);
    run_scan(1'b0, 13, 0, 1'b0);
    run_scan(1'b0, 0, 22, 1'b0);
    run_scan(1'b0, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
